// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the access size encoding, the controller state enum and the alignment
// rule, so the lane merger and the top agree on what is misaligned.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;  // 2'b11 is also handled as a word

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Halves need addr[0]=0; words (including size 2'b11) need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lo[0];
      default: mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Combinational lane merger for sub-word stores.
// Ports:
//   old_word_i  current contents of the addressed word
//   wdata_i     store data, sub-word values in the low bits
//   size_i      access size (mem_pkg SZ_*)
//   addr_lo_i   byte offset within the word (addr[1:0])
//   merged_o    word to write back (little-endian lanes)
//   misalign_o  access is unaligned for its size
module mem_lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] merged_o,
  output logic        misalign_o
);

  always_comb begin
    merged_o   = old_word_i;
    misalign_o = is_misaligned(size_i, addr_lo_i);
    case (size_i)
      SZ_BYTE: merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_HALF: begin
        if (addr_lo_i[1]) merged_o[31:16] = wdata_i[15:0];
        else              merged_o[15:0]  = wdata_i[15:0];
      end
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for a pipelined core's memory stage.
// An access is captured in IDLE, waits LATENCY cycles in BUSY, performs the
// read or read-modify-write on the last BUSY edge, and pulses ready in RESP.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req, we, size     access request, store flag, access size
//   addr, wdata       byte address, store data
//   rdata             full aligned word from the last completed load
//   ready             one-cycle completion pulse
//   stall             pipeline hold, req & ~ready
//   misalign          unaligned access flag, valid with ready
//
// state   | meaning
// IDLE    | waiting for req; captures the access on the accepting edge
// BUSY    | counting down the latency; access happens when counter is 0
// RESP    | ready high for one cycle, then back to IDLE
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        stall,
  output logic        misalign
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q;
  logic                 we_q;
  logic [1:0]           size_q;
  logic [IDX_W+1:0]     addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q;
  logic                 misalign_q;
  logic [31:0]          mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0]     idx;
  logic [31:0]          cur_word;
  logic [31:0]          merged;
  logic                 acc_mis;
  logic                 accept;
  logic                 access_fire;

  // Upper address bits are deliberately dropped so addresses wrap.
  logic                 unused_addr_hi;
  assign unused_addr_hi = ^addr[31:IDX_W+2];

  assign idx         = addr_q[IDX_W+1:2];
  assign cur_word    = mem_q[idx];
  assign accept      = (state_q == ST_IDLE) && req;
  assign access_fire = (state_q == ST_BUSY) && (cnt_q == 4'd0);

  mem_lane_merge u_merge (
    .old_word_i (cur_word),
    .wdata_i    (wdata_q),
    .size_i     (size_q),
    .addr_lo_i  (addr_q[1:0]),
    .merged_o   (merged),
    .misalign_o (acc_mis)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req) state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == 4'd0) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready    = (state_q == ST_RESP);
    stall    = req & ~ready;
    rdata    = rdata_q;
    misalign = misalign_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= 4'd0;
      rdata_q    <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= we;
        size_q  <= size;
        addr_q  <= addr[IDX_W+1:0];
        wdata_q <= wdata;
        cnt_q   <= CNT_INIT;
      end else if (state_q == ST_BUSY && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (access_fire) begin
        misalign_q <= acc_mis;
        if (!we_q) rdata_q <= acc_mis ? 32'd0 : cur_word;
      end
    end
  end

  // Storage is not cleared by reset; reset only blocks a pending write.
  always_ff @(posedge clk) begin
    if (!reset && access_fire && we_q && !acc_mis) mem_q[idx] <= merged;
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        stall;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .we       (we),
    .size     (size),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .stall    (stall),
    .misalign (misalign)
  );

  always #5 clk = ~clk;

  // One access: req raised in cycle 0, held until ready is seen.
  task automatic access(input logic we_v, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output int rc, output int sc,
                        output logic mis, output logic [31:0] rd);
    @(posedge clk); #1;
    req = 1'b1; we = we_v; size = sz; addr = a; wdata = wd;
    rc = -1; sc = 0; mis = 1'bx; rd = 'x;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (stall) sc++;
      if (ready) begin
        rc = c; mis = misalign; rd = rdata;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; we = 1'b0; size = SZ_WORD; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b0)     begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
    checks++; if (rdata !== 32'd0)    begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    checks++; if (misalign !== 1'b0)  begin errors++; $display("FAIL reset_misalign got %b exp 0", misalign); end
    checks++; if (stall !== 1'b0)     begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
  endtask

  task automatic test_word();
    int rc, sc; logic mis; logic [31:0] rd;
    access(1'b1, SZ_WORD, 32'h10, 32'hDEADBEEF, rc, sc, mis, rd);
    checks++; if (rc !== 3)       begin errors++; $display("FAIL wst_ready_cycle got %0d exp 3", rc); end
    checks++; if (sc !== 3)       begin errors++; $display("FAIL wst_stall_cycles got %0d exp 3", sc); end
    checks++; if (rd !== 32'd0)   begin errors++; $display("FAIL wst_rdata_kept got %h exp 0", rd); end
    access(1'b0, SZ_WORD, 32'h10, 32'h0, rc, sc, mis, rd);
    checks++; if (rc !== 3)       begin errors++; $display("FAIL wld_ready_cycle got %0d exp 3", rc); end
    checks++; if (sc !== 3)       begin errors++; $display("FAIL wld_stall_cycles got %0d exp 3", sc); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wld_rdata got %h exp deadbeef", rd); end
    checks++; if (mis !== 1'b0)   begin errors++; $display("FAIL wld_misalign got %b exp 0", mis); end
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL idle_stall got %b exp 0", stall); end
  endtask

  task automatic test_subword();
    int rc, sc; logic mis; logic [31:0] rd;
    access(1'b1, SZ_BYTE, 32'h11, 32'h000000AA, rc, sc, mis, rd);
    checks++; if (mis !== 1'b0)   begin errors++; $display("FAIL bst_misalign got %b exp 0", mis); end
    access(1'b1, SZ_HALF, 32'h12, 32'h00001234, rc, sc, mis, rd);
    checks++; if (mis !== 1'b0)   begin errors++; $display("FAIL hst_misalign got %b exp 0", mis); end
    access(1'b0, SZ_WORD, 32'h10, 32'h0, rc, sc, mis, rd);
    checks++; if (rd !== 32'h1234AAEF) begin errors++; $display("FAIL merge_rdata got %h exp 1234aaef", rd); end
  endtask

  task automatic test_misalign();
    int rc, sc; logic mis; logic [31:0] rd;
    access(1'b0, SZ_WORD, 32'h13, 32'h0, rc, sc, mis, rd);
    checks++; if (mis !== 1'b1)   begin errors++; $display("FAIL mis_ld_flag got %b exp 1", mis); end
    checks++; if (rd !== 32'd0)   begin errors++; $display("FAIL mis_ld_rdata got %h exp 0", rd); end
    checks++; if (rc !== 3)       begin errors++; $display("FAIL mis_ld_ready_cycle got %0d exp 3", rc); end
    access(1'b0, SZ_WORD, 32'h10, 32'h0, rc, sc, mis, rd);
    checks++; if (mis !== 1'b0)   begin errors++; $display("FAIL mis_clear got %b exp 0", mis); end
    checks++; if (rd !== 32'h1234AAEF) begin errors++; $display("FAIL mis_word_kept got %h exp 1234aaef", rd); end
    access(1'b1, SZ_HALF, 32'h11, 32'h0000FFFF, rc, sc, mis, rd);
    checks++; if (mis !== 1'b1)   begin errors++; $display("FAIL mis_st_flag got %b exp 1", mis); end
    checks++; if (rd !== 32'h1234AAEF) begin errors++; $display("FAIL mis_st_rdata_kept got %h exp 1234aaef", rd); end
    access(1'b0, SZ_BYTE, 32'h10, 32'h0, rc, sc, mis, rd);
    checks++; if (rd !== 32'h1234AAEF) begin errors++; $display("FAIL mis_st_nowrite got %h exp 1234aaef", rd); end
  endtask

  task automatic test_wrap_and_size3();
    int rc, sc; logic mis; logic [31:0] rd;
    access(1'b1, SZ_WORD, 32'h400, 32'h00000055, rc, sc, mis, rd);
    access(1'b0, SZ_WORD, 32'h0, 32'h0, rc, sc, mis, rd);
    checks++; if (rd !== 32'h00000055) begin errors++; $display("FAIL wrap_rdata got %h exp 00000055", rd); end
    access(1'b1, 2'b11, 32'h30, 32'hCAFEF00D, rc, sc, mis, rd);
    access(1'b0, SZ_BYTE, 32'h31, 32'h0, rc, sc, mis, rd);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL size3_rdata got %h exp cafef00d", rd); end
  endtask

  task automatic test_reset_abort();
    int rc, sc; logic mis; logic [31:0] rd; int pulses;
    access(1'b1, SZ_WORD, 32'h20, 32'h11223344, rc, sc, mis, rd);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; size = SZ_WORD; addr = 32'h20; wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    reset = 1'b1; req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL abort_state got %0d exp 0", dut.state_q); end
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_ready_pulses got %0d exp 0", pulses); end
    access(1'b0, SZ_WORD, 32'h20, 32'h0, rc, sc, mis, rd);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL abort_nowrite got %h exp 11223344", rd); end
  endtask

  task automatic test_back_to_back();
    int r1, r2; logic exp_stall;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; size = SZ_WORD; addr = 32'h10; wdata = 32'h0;
    r1 = -1; r2 = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_stall = !(c == 3 || c == 7);
      checks++;
      if (stall !== exp_stall) begin
        errors++; $display("FAIL b2b_stall cycle %0d got %b exp %b", c, stall, exp_stall);
      end
      if (ready) begin
        if (r1 < 0) r1 = c;
        else if (r2 < 0) r2 = c;
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    checks++; if (r1 !== 3) begin errors++; $display("FAIL b2b_first_ready got %0d exp 3", r1); end
    checks++; if (r2 !== 7) begin errors++; $display("FAIL b2b_second_ready got %0d exp 7", r2); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_misalign();
    test_wrap_and_size3();
    test_reset_abort();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
